// File: rtl/truth_table_scan_pkg.sv
// truth_table_scan_pkg
// Shared definitions for the truth-table scanner:
//   scan_state_t  - scanner FSM state encoding
//   DEF_N_IN      - default width of the swept input code
//   DEF_SETTLE    - default idle cycles between driving a code and sampling
//   table_width() - number of truth-table entries for a given input width
package truth_table_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 1;

    function automatic int table_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// scan_settle_timer
// Loadable down-counter that stops at zero; zero is flagged combinationally
// so the FSM can leave its wait state in the cycle the count runs out.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (count cleared)
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load
//   zero     - count is at its terminal value
module scan_settle_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_scan.sv
// truth_table_scan
// Sweeps every input code through an external combinational block, waits
// SETTLE cycles per code, samples the block's result and publishes the full
// truth table plus its number of ones. Published outputs hold the previous
// result until a scan completes.
// Optional feature macro: TRUTH_TABLE_SCAN_CHECK_EN adds a compare against
// an expected table (ports expected, mismatch, mismatch_idx).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - scan request, only honoured in IDLE
//   a_out        - code currently driven to the block under scan
//   d_in         - block result for a_out
//   busy         - scan in progress
//   done         - one-cycle pulse when table_out/ones_cnt update
//   table_out    - bit i = result sampled for code i
//   ones_cnt     - number of ones in table_out
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start; outputs hold last result
// ST_SETTLE | code driven, settle timer running
// ST_SAMPLE | d_in captured into shadow table for current code
// ST_DONE   | shadow published, done pulse
module truth_table_scan
    import truth_table_scan_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [N_IN-1:0]               a_out,
    input  logic                          d_in,
    output logic                          busy,
    output logic                          done,
    output logic [table_width(N_IN)-1:0]  table_out,
    output logic [N_IN:0]                 ones_cnt
`ifdef TRUTH_TABLE_SCAN_CHECK_EN
    ,
    input  logic [table_width(N_IN)-1:0]  expected,
    output logic                          mismatch,
    output logic [N_IN-1:0]               mismatch_idx
`endif
);

    localparam int TBL_W = table_width(N_IN);
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TBL_W - 1);
    // With no settle time the FSM goes straight from one sample to the next.
    localparam scan_state_t ST_WAIT = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    scan_state_t      state;
    scan_state_t      state_next;
    logic [N_IN:0]    idx;
    logic [TBL_W-1:0] shadow;
    logic [TBL_W-1:0] shadow_next;
    logic [N_IN:0]    count;
    logic [N_IN:0]    count_next;
    logic             accept;
    logic             last;
    logic             timer_load;
    logic             timer_zero;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (idx == LAST_IDX);
    assign a_out  = idx[N_IN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start)      state_next = ST_WAIT;
            ST_SETTLE: if (timer_zero) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = last ? ST_DONE : ST_WAIT;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == ST_SETTLE) || (state == ST_SAMPLE);
        done       = (state == ST_DONE);
        timer_load = accept || ((state == ST_SAMPLE) && !last);
    end

    generate
        if (SETTLE == 0) begin : g_no_settle
            logic unused_timer_load;
            assign unused_timer_load = timer_load;
            assign timer_zero        = 1'b1;
        end else begin : g_settle
            localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
            scan_settle_timer #(.WIDTH(TW)) u_timer (
                .clk      (clk),
                .rst      (rst),
                .load     (timer_load),
                .load_val (TW'(SETTLE - 1)),
                .zero     (timer_zero)
            );
        end
    endgenerate

    // Shadow including the current sample, so the last code can be published
    // on the same edge that enters ST_DONE.
    always_comb begin
        shadow_next                   = shadow;
        shadow_next[idx[N_IN-1:0]]    = d_in;
        count_next                    = count + {{N_IN{1'b0}}, d_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            shadow    <= '0;
            count     <= '0;
            table_out <= '0;
            ones_cnt  <= '0;
        end else if (accept) begin
            idx    <= '0;
            shadow <= '0;
            count  <= '0;
        end else if (state == ST_SAMPLE) begin
            shadow <= shadow_next;
            count  <= count_next;
            if (last) begin
                table_out <= shadow_next;
                ones_cnt  <= count_next;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef TRUTH_TABLE_SCAN_CHECK_EN
    logic [TBL_W-1:0] diff;
    logic [N_IN-1:0]  first_diff;

    // Descending walk so the lowest differing code wins.
    always_comb begin
        diff       = shadow_next ^ expected;
        first_diff = '0;
        for (int i = TBL_W - 1; i >= 0; i--) begin
            if (diff[i]) first_diff = N_IN'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
        end else if ((state == ST_SAMPLE) && last) begin
            mismatch     <= |diff;
            mismatch_idx <= first_diff;
        end
    end
`else
    // Compare logic not built.
`endif

endmodule

// File: tb/tb_truth_table_scan.sv
module tb_truth_table_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start  [3];
    logic [3:0]  a_o    [3];
    logic        d_in   [3];
    logic        busy   [3];
    logic        done   [3];
    logic [15:0] tbl    [3];
    logic [4:0]  cnt    [3];
    int          mode   [3];
    logic [15:0] lut    [3];
    logic [15:0] prev_tbl [3];
`ifdef TRUTH_TABLE_SCAN_CHECK_EN
    logic [15:0] exp_in [3];
    logic        mm     [3];
    logic [3:0]  mm_idx [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Function under scan, chosen per instance.
    function automatic logic model_d(input int m, input logic [15:0] l, input logic [3:0] a);
        case (m)
            0:       return a[0] & a[3];
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return a[1];
            4:       return l[a];
            5:       return (a[0] & a[3]) ^ (a == 4'd5);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int S_G = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
            assign d_in[g] = model_d(mode[g], lut[g], a_o[g]);
            truth_table_scan #(.N_IN(4), .SETTLE(S_G)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start[g]),
                .a_out     (a_o[g]),
                .d_in      (d_in[g]),
                .busy      (busy[g]),
                .done      (done[g]),
                .table_out (tbl[g]),
                .ones_cnt  (cnt[g])
`ifdef TRUTH_TABLE_SCAN_CHECK_EN
                ,
                .expected     (exp_in[g]),
                .mismatch     (mm[g]),
                .mismatch_idx (mm_idx[g])
`endif
            );
        end
    endgenerate

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Waits (bounded) for done on instance k; returns cycle of done counted
    // from 1 = first busy cycle. Also counts a_out sequence and hold errors.
    task automatic wait_done(input int k, input int limit, output int cyc,
                             output int bad_a, output int bad_hold);
        int s;
        s        = settle_of(k);
        cyc      = 1;
        bad_a    = 0;
        bad_hold = 0;
        while (!done[k] && cyc < limit) begin
            if (int'(a_o[k]) != (cyc - 1) / (s + 1)) bad_a++;
            if (tbl[k] !== prev_tbl[k] || busy[k] !== 1'b1) bad_hold++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_scan(input int k, input int mode_v, input logic [15:0] lut_v,
                            input logic hold, input logic [15:0] exp_tbl,
                            input int exp_cnt, input int exp_cyc, input string nm);
        int cyc, bad_a, bad_hold;
        mode[k] = mode_v;
        lut[k]  = lut_v;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        if (!hold) start[k] = 1'b0;
        check({nm, " busy_c1"}, busy[k], 1);
        check({nm, " a_out_c1"}, a_o[k], 0);
        wait_done(k, exp_cyc + 20, cyc, bad_a, bad_hold);
        check({nm, " done_cycle"}, cyc, exp_cyc);
        check({nm, " a_out_seq_errs"}, bad_a, 0);
        check({nm, " hold_errs"}, bad_hold, 0);
        check({nm, " table"}, tbl[k], exp_tbl);
        check({nm, " ones_cnt"}, cnt[k], exp_cnt);
        check({nm, " busy_at_done"}, busy[k], 0);
        prev_tbl[k] = exp_tbl;
        @(negedge clk);
        check({nm, " done_pulse_end"}, done[k], 0);
        if (hold) begin
            check({nm, " busy_after_done"}, busy[k], 0);
            @(negedge clk);
            check({nm, " reaccept_busy"}, busy[k], 1);
            check({nm, " reaccept_a_out"}, a_o[k], 0);
            start[k] = 1'b0;
            wait_done(k, exp_cyc + 20, cyc, bad_a, bad_hold);
            check({nm, " second_done_cycle"}, cyc, exp_cyc);
            check({nm, " second_table"}, tbl[k], exp_tbl);
            @(negedge clk);
        end
    endtask

    typedef struct {
        int          k;
        int          m;
        logic        hold;
        logic [15:0] exp_tbl;
        int          exp_cnt;
        int          exp_cyc;
        string       nm;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   cyc, n_done;

        for (int k = 0; k < 3; k++) begin
            start[k]    = 1'b0;
            mode[k]     = 2;
            lut[k]      = '0;
            prev_tbl[k] = '0;
`ifdef TRUTH_TABLE_SCAN_CHECK_EN
            exp_in[k]   = '0;
`endif
        end

        vecs[0] = '{0, 0, 1'b0, 16'hAA00, 4,  33, "a0_and_a3"};
        vecs[1] = '{1, 1, 1'b0, 16'hFFFF, 16, 17, "const1_settle0"};
        vecs[2] = '{0, 2, 1'b0, 16'h0000, 0,  33, "const0"};
        vecs[3] = '{0, 3, 1'b0, 16'hCCCC, 8,  33, "a1_back_to_back"};
        vecs[4] = '{2, 0, 1'b1, 16'hAA00, 4,  49, "settle2_start_held"};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("reset a_out", a_o[k], 0);
            check("reset busy", busy[k], 0);
            check("reset done", done[k], 0);
            check("reset table", tbl[k], 0);
            check("reset ones_cnt", cnt[k], 0);
        end

        for (int v = 0; v < 5; v++) begin
            run_scan(vecs[v].k, vecs[v].m, 16'h0, vecs[v].hold, vecs[v].exp_tbl,
                     vecs[v].exp_cnt, vecs[v].exp_cyc, vecs[v].nm);
        end

        // Random lookup-table functions on random instances.
        for (int r = 0; r < 6; r++) begin
            int          k, ones;
            logic [15:0] l;
            k    = int'($urandom_range(0, 2));
            l    = 16'($urandom);
            ones = 0;
            for (int i = 0; i < 16; i++) ones += int'(l[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_scan(k, 4, l, 1'b0, l, ones, 1 + 16 * (settle_of(k) + 1), "random_lut");
        end

        // Reset in the middle of a scan.
        mode[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst a_out", a_o[0], 0);
        check("midrst busy", busy[0], 0);
        check("midrst done", done[0], 0);
        check("midrst table", tbl[0], 0);
        check("midrst ones_cnt", cnt[0], 0);
        for (int k = 0; k < 3; k++) prev_tbl[k] = '0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0] || busy[0]) n_done++;
        end
        check("midrst no_activity", n_done, 0);
        run_scan(0, 0, 16'h0, 1'b0, 16'hAA00, 4, 33, "after_reset");

`ifdef TRUTH_TABLE_SCAN_CHECK_EN
        exp_in[0] = 16'hAA00;
        run_scan(0, 5, 16'h0, 1'b0, 16'hAA20, 5, 33, "check_en");
        check("check_en mismatch", mm[0], 1);
        check("check_en mismatch_idx", mm_idx[0], 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
